// File: rtl/mram_seq_ctrl.sv
// MRAM command sequencer: accepts one read/write command at a time and drives the
// address/data shift-in, MRAM strobes, read access wait, load and serial shift-out.
module mram_seq_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 1,
    parameter int WR_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [DATA_W/8-1:0] cmd_be,
    input  logic                abort,
    output logic                done,
    output logic                data_en,
    output logic                addr_en,
    output logic                send_data,
    output logic                load,
    output logic                data_in_from_MRAM_en,
    output logic                chip_en,
    output logic                write_en,
    output logic                out_en,
    output logic [DATA_W/8-1:0] byte_en_n
);

    localparam int BYTES     = DATA_W / 8;
    localparam int SHIFT_MAX = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int LEN_A     = (SHIFT_MAX > RD_WAIT + 1) ? SHIFT_MAX : RD_WAIT + 1;
    localparam int MAX_LEN   = (LEN_A > WR_CYC) ? LEN_A : WR_CYC;
    localparam int CNT_W     = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] ADDR_LEN  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LEN  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        NOP       = 3'd1,
        SHIFT_IN  = 3'd2,
        WR_STROBE = 3'd3,
        RD_ACCESS = 3'd4,
        RD_LOAD   = 3'd5,
        SHIFT_OUT = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [BYTES-1:0]   be_q, be_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               done_q, done_d;
    logic               data_en_q, data_en_d;
    logic               addr_en_q, addr_en_d;
    logic               send_data_q, send_data_d;
    logic               load_q, load_d;
    logic               dimen_q, dimen_d;
    logic               chip_en_q, chip_en_d;
    logic               write_en_q, write_en_d;
    logic               out_en_q, out_en_d;
    logic [BYTES-1:0]   byte_en_n_q, byte_en_n_d;

    logic [CNT_W-1:0]   shift_last;
    logic [CNT_W-1:0]   out_last;

    // Shift-out length in bits: 8 per selected byte lane.
    function automatic logic [CNT_W-1:0] lane_bits(input logic [BYTES-1:0] be);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < BYTES; i++) begin
            n = n + CNT_W'(be[i]);
        end
        return n << 3;
    endfunction

    always_comb begin
        shift_last = ADDR_LAST;
        if (we_q && (DATA_LAST > ADDR_LAST)) begin
            shift_last = DATA_LAST;
        end
        out_last = lane_bits(be_q) - 1'b1;
    end

    // Handshake: a command is taken on any edge where cmd_valid && cmd_ready are both
    // high; cmd_ready is only high in IDLE and the cmd_* inputs are latched at that edge.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d    = cmd_we;
                    be_d    = cmd_be;
                    state_d = (cmd_be == '0) ? NOP : SHIFT_IN;
                end
            end
            NOP:       state_d = DONE;
            SHIFT_IN: begin
                if (cnt_q == shift_last) begin
                    state_d = we_q ? WR_STROBE : RD_ACCESS;
                end
            end
            WR_STROBE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = DONE;
                end
            end
            RD_ACCESS: begin
                if (cnt_q == RD_LAST) begin
                    state_d = RD_LOAD;
                end
            end
            RD_LOAD:   state_d = SHIFT_OUT;
            SHIFT_OUT: begin
                if (cnt_q == out_last) begin
                    state_d = DONE;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        // Counter restarts on every state entry and idles at zero.
        if ((state_d != state_q) || (state_d == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they are registered yet cycle-aligned.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        done_d      = 1'b0;
        data_en_d   = 1'b0;
        addr_en_d   = 1'b0;
        send_data_d = 1'b0;
        load_d      = 1'b0;
        dimen_d     = 1'b0;
        chip_en_d   = 1'b1;
        write_en_d  = 1'b1;
        out_en_d    = 1'b1;
        byte_en_n_d = '1;

        unique case (state_d)
            SHIFT_IN: begin
                addr_en_d = (cnt_d < ADDR_LEN);
                data_en_d = we_d && (cnt_d < DATA_LEN);
            end
            WR_STROBE: begin
                send_data_d = 1'b1;
                chip_en_d   = 1'b0;
                write_en_d  = 1'b0;
                byte_en_n_d = ~be_d;
            end
            RD_ACCESS: begin
                send_data_d = 1'b1;
                chip_en_d   = 1'b0;
                out_en_d    = 1'b0;
                byte_en_n_d = ~be_d;
            end
            RD_LOAD: begin
                load_d      = 1'b1;
                dimen_d     = 1'b1;
                chip_en_d   = 1'b0;
                out_en_d    = 1'b0;
                byte_en_n_d = ~be_d;
            end
            SHIFT_OUT: begin
                send_data_d = 1'b1;
                dimen_d     = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            data_en_q   <= 1'b0;
            addr_en_q   <= 1'b0;
            send_data_q <= 1'b0;
            load_q      <= 1'b0;
            dimen_q     <= 1'b0;
            chip_en_q   <= 1'b1;
            write_en_q  <= 1'b1;
            out_en_q    <= 1'b1;
            byte_en_n_q <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            be_q        <= be_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            data_en_q   <= data_en_d;
            addr_en_q   <= addr_en_d;
            send_data_q <= send_data_d;
            load_q      <= load_d;
            dimen_q     <= dimen_d;
            chip_en_q   <= chip_en_d;
            write_en_q  <= write_en_d;
            out_en_q    <= out_en_d;
            byte_en_n_q <= byte_en_n_d;
        end
    end

    assign cmd_ready            = cmd_ready_q;
    assign done                 = done_q;
    assign data_en              = data_en_q;
    assign addr_en              = addr_en_q;
    assign send_data            = send_data_q;
    assign load                 = load_q;
    assign data_in_from_MRAM_en = dimen_q;
    assign chip_en              = chip_en_q;
    assign write_en             = write_en_q;
    assign out_en               = out_en_q;
    assign byte_en_n            = byte_en_n_q;

endmodule

// File: tb/tb_mram_seq_ctrl.sv
// Directed bench for mram_seq_ctrl at default parameters; cycle k counts edges
// after the accept edge and outputs are sampled on the falling edge.
module tb_mram_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_we;
    logic [1:0] cmd_be;
    logic       abort;
    logic       cmd_ready, done, data_en, addr_en, send_data, load;
    logic       data_in_from_MRAM_en, chip_en, write_en, out_en;
    logic [1:0] byte_en_n;

    int checks   = 0;
    int failures = 0;

    // {cmd_ready, done, data_en, addr_en, send_data, load, dimen, chip_en, write_en, out_en, byte_en_n}
    wire [11:0] obs = {cmd_ready, done, data_en, addr_en, send_data, load,
                       data_in_from_MRAM_en, chip_en, write_en, out_en, byte_en_n};

    localparam logic [11:0] RST_VEC   = 12'b0000_0001_1111;
    localparam logic [11:0] READY_VEC = 12'b1000_0001_1111;
    localparam logic [11:0] DONE_VEC  = 12'b0100_0001_1111;

    mram_seq_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_we               (cmd_we),
        .cmd_be               (cmd_be),
        .abort                (abort),
        .done                 (done),
        .data_en              (data_en),
        .addr_en              (addr_en),
        .send_data            (send_data),
        .load                 (load),
        .data_in_from_MRAM_en (data_in_from_MRAM_en),
        .chip_en              (chip_en),
        .write_en             (write_en),
        .out_en               (out_en),
        .byte_en_n            (byte_en_n)
    );

    always #5 clk = ~clk;

    task automatic do_accept(input logic we, input logic [1:0] be);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait got=%b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_be    = be;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_be    = ~be;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_be    = 2'b11;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", obs, RST_VEC);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== READY_VEC) begin
            failures++;
            $display("FAIL reset_ready_rise got=%b exp=%b", obs, READY_VEC);
        end
    endtask

    // Abort is held high during the IDLE accept to confirm it is ignored there.
    task automatic test_write(input logic [1:0] be);
        logic [11:0] exp;
        logic        st;
        abort = 1'b1;
        do_accept(1'b1, be);
        abort = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            st  = (k == 21);
            exp = {k == 23, k == 22, k <= 16, k <= 20, st, 1'b0, 1'b0,
                   !st, !st, 1'b1, st ? ~be : 2'b11};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL write be=%b k=%0d got=%b exp=%b", be, k, obs, exp);
            end
        end
    endtask

    task automatic test_read(input logic [1:0] be);
        logic [11:0] exp;
        logic        acc;
        int          l;
        l = 24 + 8 * (int'(be[0]) + int'(be[1]));
        do_accept(1'b0, be);
        for (int k = 1; k <= l + 1; k++) begin
            @(negedge clk);
            acc = (k >= 21) && (k <= 23);
            exp = {k == l + 1, k == l, 1'b0, k <= 20,
                   (k == 21 || k == 22) || (k >= 24 && k < l), k == 23,
                   (k >= 23) && (k < l), !acc, 1'b1, !acc, acc ? ~be : 2'b11};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL read be=%b k=%0d got=%b exp=%b", be, k, obs, exp);
            end
        end
    endtask

    // cmd_valid stays high through DONE: the next nop is only taken back in IDLE.
    task automatic test_nop();
        logic [11:0] exp_tab [6];
        int          n;
        exp_tab = '{RST_VEC, DONE_VEC, READY_VEC, RST_VEC, DONE_VEC, READY_VEC};
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_be    = 2'b00;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_tab[k-1]) begin
                failures++;
                $display("FAIL nop k=%0d got=%b exp=%b", k, obs, exp_tab[k-1]);
            end
            if (k == 4) cmd_valid = 1'b0;
        end
    endtask

    // Abort lands on the last RD_ACCESS cycle, where it competes with RD_LOAD entry.
    task automatic test_abort();
        logic [11:0] acc_vec;
        acc_vec = 12'b0000_1000_1010;
        do_accept(1'b0, 2'b01);
        repeat (21) @(negedge clk);
        checks++;
        if (obs !== acc_vec) begin
            failures++;
            $display("FAIL abort_pre k=21 got=%b exp=%b", obs, acc_vec);
        end
        @(negedge clk);
        checks++;
        if (obs !== acc_vec) begin
            failures++;
            $display("FAIL abort_pre k=22 got=%b exp=%b", obs, acc_vec);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (obs !== READY_VEC) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=%b", obs, READY_VEC);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== READY_VEC) begin
                failures++;
                $display("FAIL abort_quiet n=%0d got=%b exp=%b", k, obs, READY_VEC);
            end
        end
        test_write(2'b10);
    endtask

    task automatic test_rst_mid();
        logic [11:0] wr_vec;
        wr_vec = 12'b0000_1000_0100;
        do_accept(1'b1, 2'b11);
        repeat (21) @(negedge clk);
        checks++;
        if (obs !== wr_vec) begin
            failures++;
            $display("FAIL rst_mid_strobe got=%b exp=%b", obs, wr_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL rst_mid_reset got=%b exp=%b", obs, RST_VEC);
        end
        @(negedge clk);
        checks++;
        if (obs !== READY_VEC) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b exp=%b", obs, READY_VEC);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_be    = 2'b00;
        abort     = 1'b0;
        test_reset();
        test_write(2'b11);
        test_read(2'b01);
        test_read(2'b11);
        test_nop();
        test_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
